// File: rtl/tl_pkg.sv
// Shared phase codes and default timing for the traffic-light sequencer
// and its downstream lamp decoder.
package tl_pkg;

   localparam logic [2:0] TL_START = 3'b111;
   localparam logic [2:0] TL_NS    = 3'b011;
   localparam logic [2:0] TL_NY    = 3'b010;
   localparam logic [2:0] TL_EW    = 3'b000;
   localparam logic [2:0] TL_EY    = 3'b001;

   localparam logic [11:0] TL_START_TIME = 12'd20;
   localparam logic [11:0] TL_NS_TIME    = 12'd90;
   localparam logic [11:0] TL_EW_TIME    = 12'd60;
   localparam logic [11:0] TL_Y_TIME     = 12'd30;
   localparam logic [11:0] TL_AR_TIME    = 12'd10;
   localparam logic [11:0] TL_MIN_GREEN  = 12'd20;

   // Upper bits tell apart the three phases that share the all-red code.
   typedef enum logic [4:0] {
      ST_START = {2'b00, TL_START},
      ST_NSG   = {2'b00, TL_NS},
      ST_NSY   = {2'b00, TL_NY},
      ST_ARN   = {2'b01, TL_START},
      ST_EWG   = {2'b00, TL_EW},
      ST_EWY   = {2'b00, TL_EY},
      ST_ARE   = {2'b10, TL_START}
   } tl_state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase elapsed-tick counter with expiry, minimum-green and
// remaining-time outputs.
module tl_phase_timer
   import tl_pkg::*;
#(
   parameter int T_WIDTH = 12,
   parameter logic [T_WIDTH-1:0] MIN_GREEN = T_WIDTH'(TL_MIN_GREEN)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic               i_load,
   input  logic [T_WIDTH-1:0] i_dur,
   output logic               o_expire,
   output logic               o_min_met,
   output logic [T_WIDTH-1:0] o_remaining
);

   logic [T_WIDTH-1:0] r_elapsed;
   logic [T_WIDTH-1:0] w_last;
   logic [T_WIDTH-1:0] w_min_last;

   assign w_last     = i_dur - 1'b1;
   assign w_min_last = MIN_GREEN - 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_elapsed <= '0;
      else if (i_load)
         r_elapsed <= '0;
      else if (i_tick)
         r_elapsed <= r_elapsed + 1'b1;
   end

   assign o_expire    = (r_elapsed == w_last);
   assign o_min_met   = (r_elapsed >= w_min_last);
   assign o_remaining = w_last - r_elapsed;

endmodule

// File: rtl/tl_phase_sequencer.sv
// NS/EW phase sequencer with all-red clearance, demand-driven early
// green termination and a countdown of the current phase.
module tl_phase_sequencer
   import tl_pkg::*;
#(
   parameter int T_WIDTH = 12,
   parameter logic [T_WIDTH-1:0] START_TIME = T_WIDTH'(TL_START_TIME),
   parameter logic [T_WIDTH-1:0] NS_TIME    = T_WIDTH'(TL_NS_TIME),
   parameter logic [T_WIDTH-1:0] EW_TIME    = T_WIDTH'(TL_EW_TIME),
   parameter logic [T_WIDTH-1:0] Y_TIME     = T_WIDTH'(TL_Y_TIME),
   parameter logic [T_WIDTH-1:0] AR_TIME    = T_WIDTH'(TL_AR_TIME),
   parameter logic [T_WIDTH-1:0] MIN_GREEN  = T_WIDTH'(TL_MIN_GREEN)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic               i_req_ns,
   input  logic               i_req_ew,
   output logic [2:0]         o_state,
   output logic [T_WIDTH-1:0] o_remaining,
   output logic               o_phase_done
);

   tl_state_t          r_state;
   logic               r_req_ns;
   logic               r_req_ew;
   logic               r_phase_done;
   logic [T_WIDTH-1:0] w_dur;
   logic               w_expire;
   logic               w_min_met;
   logic               w_early;
   logic               w_adv;
   logic               w_bad;
   logic               w_enter_ns;
   logic               w_enter_ew;

   always_comb begin
      w_dur = START_TIME;
      case (r_state)
         ST_NSG:         w_dur = NS_TIME;
         ST_EWG:         w_dur = EW_TIME;
         ST_NSY, ST_EWY: w_dur = Y_TIME;
         ST_ARN, ST_ARE: w_dur = AR_TIME;
         default:        w_dur = START_TIME;
      endcase
   end

   assign w_bad = !(r_state inside {ST_START, ST_NSG, ST_NSY, ST_ARN,
                                    ST_EWG, ST_EWY, ST_ARE});

   assign w_early = w_min_met &
                    (((r_state == ST_NSG) & r_req_ew) |
                     ((r_state == ST_EWG) & r_req_ns));

   assign w_adv      = i_tick & (w_expire | w_early) & !w_bad;
   assign w_enter_ns = w_adv & ((r_state == ST_START) | (r_state == ST_ARE));
   assign w_enter_ew = w_adv & (r_state == ST_ARN);

   tl_phase_timer #(
      .T_WIDTH   (T_WIDTH),
      .MIN_GREEN (MIN_GREEN)
   ) u_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_tick      (i_tick),
      .i_load      (w_adv | w_bad),
      .i_dur       (w_dur),
      .o_expire    (w_expire),
      .o_min_met   (w_min_met),
      .o_remaining (o_remaining)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_START;
         r_phase_done <= 1'b0;
         r_req_ns     <= 1'b0;
         r_req_ew     <= 1'b0;
      end else begin
         r_phase_done <= w_adv;
         case (r_state)
            ST_START: if (w_adv) r_state <= ST_NSG;
            ST_NSG:   if (w_adv) r_state <= ST_NSY;
            ST_NSY:   if (w_adv) r_state <= ST_ARN;
            ST_ARN:   if (w_adv) r_state <= ST_EWG;
            ST_EWG:   if (w_adv) r_state <= ST_EWY;
            ST_EWY:   if (w_adv) r_state <= ST_ARE;
            ST_ARE:   if (w_adv) r_state <= ST_NSG;
            default:  r_state <= ST_START;
         endcase
         // Clear on green entry wins; own-green demand is not latched.
         if (w_enter_ns)
            r_req_ns <= 1'b0;
         else if (i_req_ns && (r_state != ST_NSG))
            r_req_ns <= 1'b1;
         if (w_enter_ew)
            r_req_ew <= 1'b0;
         else if (i_req_ew && (r_state != ST_EWG))
            r_req_ew <= 1'b1;
      end
   end

   assign o_state      = r_state[2:0];
   assign o_phase_done = r_phase_done;

endmodule
